// File: rtl/output_buffer.sv
// Registered router output stage: captures a flit on enable and presents it
// PIPE_STAGES cycles later with valid, holding the last flit while idle.
module output_buffer #(
  parameter int DATA_WIDTH  = 32,
  parameter int PIPE_STAGES = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  enable,
  input  logic [DATA_WIDTH-1:0] data_in,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  valid
);

  logic [PIPE_STAGES-1:0][DATA_WIDTH-1:0] data_q, data_d;
  logic [PIPE_STAGES-1:0]                 vld_q,  vld_d;

  // Each stage only loads when the stage feeding it holds a valid flit, so
  // idle cycles never disturb data already presented downstream.
  always_comb begin
    // NOTE: every always_comb output gets a full default first so no path
    // leaves it unassigned, which would otherwise infer a latch.
    data_d = data_q;
    vld_d  = '0;

    vld_d[0] = enable;
    if (enable) begin
      data_d[0] = data_in;
    end

    for (int k = 1; k < PIPE_STAGES; k++) begin
      vld_d[k] = vld_q[k-1];
      if (vld_q[k-1]) begin
        data_d[k] = data_q[k-1];
      end
    end
  end

  // NOTE: state flops use non-blocking assignments so every stage samples the
  // pre-edge value of its predecessor, giving a true shift rather than a
  // fall-through.
  always_ff @(posedge clk) begin
    if (rst) begin
      data_q <= '0;
      vld_q  <= '0;
    end else begin
      data_q <= data_d;
      vld_q  <= vld_d;
    end
  end

  assign data_out = data_q[PIPE_STAGES-1];
  assign valid    = vld_q[PIPE_STAGES-1];

endmodule

// File: tb/tb_output_buffer.sv
// Directed self-checking bench for output_buffer: a default 1-stage instance
// and a 3-stage instance share the same stimulus.
module tb_output_buffer;

  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic          enable;
  logic [DW-1:0] data_in;
  logic [DW-1:0] data_out1, data_out3;
  logic          valid1, valid3;

  int checks = 0;
  int errors = 0;

  logic [DW-1:0] burst_tbl [18] = '{
    32'h0000_0001, 32'h8000_0000, 32'hCAFE_F00D, 32'h1357_9BDF, 32'hFFFF_FFFE, 32'h0F0F_0F0F,
    32'h2468_ACE0, 32'h7FFF_FFFF, 32'hBAAD_C0DE, 32'h5555_5555, 32'hAAAA_AAAA, 32'h0000_FFFF,
    32'hFEED_FACE, 32'h0BAD_BEEF, 32'h3141_5926, 32'h2718_2818, 32'hC001_D00D, 32'h9999_0000
  };

  always #5 clk = ~clk;

  output_buffer #(.DATA_WIDTH(DW), .PIPE_STAGES(1)) dut1 (
    .clk      (clk),
    .rst      (rst),
    .enable   (enable),
    .data_in  (data_in),
    .data_out (data_out1),
    .valid    (valid1)
  );

  output_buffer #(.DATA_WIDTH(DW), .PIPE_STAGES(3)) dut3 (
    .clk      (clk),
    .rst      (rst),
    .enable   (enable),
    .data_in  (data_in),
    .data_out (data_out3),
    .valid    (valid3)
  );

  task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Drive one cycle of inputs, then look at outputs 1ns after the edge.
  task automatic step(input logic r, input logic en, input logic [DW-1:0] d);
    rst     = r;
    enable  = en;
    data_in = d;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; enable = 1'b0; data_in = '0;
    #1;

    // Reset, including reset overriding enable
    step(1'b1, 1'b0, 32'h0);
    step(1'b1, 1'b0, 32'h0);
    check("rst_data", data_out1, 32'h0);
    check("rst_valid", {31'b0, valid1}, 32'h0);
    step(1'b1, 1'b1, 32'hDEAD_BEEF);
    check("rst_pri_data", data_out1, 32'h0);
    check("rst_pri_valid", {31'b0, valid1}, 32'h0);
    check("rst_pri_data3", data_out3, 32'h0);

    // Single capture then hold, with changing and unknown idle data
    step(1'b0, 1'b1, 32'h1234_5678);
    check("single_data", data_out1, 32'h1234_5678);
    check("single_valid", {31'b0, valid1}, 32'h1);
    step(1'b0, 1'b0, 32'hFFFF_FFFF);
    check("single_hold_data", data_out1, 32'h1234_5678);
    check("single_hold_valid", {31'b0, valid1}, 32'h0);
    step(1'b0, 1'b0, 'x);
    check("x_hold_data", data_out1, 32'h1234_5678);
    check("x_hold_valid", {31'b0, valid1}, 32'h0);

    // Three bursts of six flits separated by two idle cycles
    for (int b = 0; b < 3; b++) begin
      for (int i = 0; i < 6; i++) begin
        step(1'b0, 1'b1, burst_tbl[b*6+i]);
        check($sformatf("burst%0d_data%0d", b, i), data_out1, burst_tbl[b*6+i]);
        check($sformatf("burst%0d_valid%0d", b, i), {31'b0, valid1}, 32'h1);
      end
      for (int i = 0; i < 2; i++) begin
        step(1'b0, 1'b0, ~burst_tbl[b*6+i]);
        check($sformatf("gap%0d_data%0d", b, i), data_out1, burst_tbl[b*6+5]);
        check($sformatf("gap%0d_valid%0d", b, i), {31'b0, valid1}, 32'h0);
      end
    end

    // Mid-burst reset discards in-flight flits in both depths
    step(1'b0, 1'b1, 32'h1111_1111);
    check("mid_f1", data_out1, 32'h1111_1111);
    step(1'b0, 1'b1, 32'h2222_2222);
    check("mid_f2", data_out1, 32'h2222_2222);
    step(1'b1, 1'b1, 32'h3333_3333);
    check("mid_rst_data", data_out1, 32'h0);
    check("mid_rst_valid", {31'b0, valid1}, 32'h0);
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b0, 32'h4444_4444);
      check($sformatf("post_rst_valid%0d", i), {31'b0, valid1}, 32'h0);
      check($sformatf("post_rst_data%0d", i), data_out1, 32'h0);
      check($sformatf("post_rst_valid3_%0d", i), {31'b0, valid3}, 32'h0);
      check($sformatf("post_rst_data3_%0d", i), data_out3, 32'h0);
    end
    step(1'b0, 1'b1, 32'h5555_AAAA);
    check("restart_data", data_out1, 32'h5555_AAAA);
    check("restart_valid", {31'b0, valid1}, 32'h1);

    // Three-stage latency with a single flit
    step(1'b1, 1'b0, 32'h0);
    step(1'b0, 1'b1, 32'hA5A5_A5A5);
    check("p3_c1_valid", {31'b0, valid3}, 32'h0);
    check("p3_c1_data", data_out3, 32'h0);
    check("p1_same_flit", data_out1, 32'hA5A5_A5A5);
    step(1'b0, 1'b0, 32'h5A5A_5A5A);
    check("p3_c2_valid", {31'b0, valid3}, 32'h0);
    check("p3_c2_data", data_out3, 32'h0);
    step(1'b0, 1'b0, 32'h5A5A_5A5A);
    check("p3_c3_valid", {31'b0, valid3}, 32'h1);
    check("p3_c3_data", data_out3, 32'hA5A5_A5A5);
    step(1'b0, 1'b0, 32'h5A5A_5A5A);
    check("p3_c4_valid", {31'b0, valid3}, 32'h0);
    check("p3_c4_data", data_out3, 32'hA5A5_A5A5);
    step(1'b0, 1'b0, 32'h5A5A_5A5A);
    check("p3_c5_valid", {31'b0, valid3}, 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
